// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge: SRAM-like CPU data port to single-beat AXI bridge; BRIDGE_RESP_ERR_EN adds a sticky response-error flag
module data_sram_axi_bridge #(
  parameter logic [3:0] ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d, data_ok_q, data_ok_d;
  assign addr_ok   = req & (state_q == IDLE);
  assign data_ok   = data_ok_q;
  assign rdata     = rdata_q;
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arsize    = {1'b0, size_q};
  assign awsize    = {1'b0, size_q};
  assign axi_wdata = wdata_q;
  assign axi_wstrb = wstrb_q;
  assign arvalid   = state_q == RD_ADDR;
  assign rready    = state_q == RD_DATA;
  assign awvalid   = (state_q == WR_REQ) & ~aw_done_q;
  assign wvalid    = (state_q == WR_REQ) & ~w_done_q;
  assign bready    = state_q == WR_RESP;
  assign arid      = ID;
  assign awid      = ID;
  assign arlen     = 8'd0;
  assign awlen     = 8'd0;
  assign arburst   = 2'b01;
  assign awburst   = 2'b01;
  assign arlock    = 1'b0;
  assign awlock    = 1'b0;
  assign arcache   = 4'd0;
  assign awcache   = 4'd0;
  assign arprot    = 3'd0;
  assign awprot    = 3'd0;
  assign wlast     = 1'b1;
  // next state: latch the request on accept, track AW/W completion independently, pulse data_ok after the last handshake
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    data_ok_d = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        addr_d    = addr;
        size_d    = (size == 2'b11) ? 2'b10 : size;
        wstrb_d   = wstrb;
        wdata_d   = wdata;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: state_d = arready ? RD_DATA : RD_ADDR;
      RD_DATA: if (rvalid) begin
        rdata_d   = axi_rdata;
        data_ok_d = 1'b1;
        state_d   = IDLE;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        state_d   = (aw_done_d & w_done_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (bvalid) begin
        data_ok_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and request registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
    end
  end
`ifdef BRIDGE_RESP_ERR_EN
  logic err_q, err_d;
  // any non-OKAY response on a completed R or B handshake sets err until reset
  always_comb err_d = err_q | (rready & rvalid & (|rresp)) | (bready & bvalid & (|bresp));
  // sticky error register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// tb_data_sram_axi_bridge: directed stimulus, AXI slave stub and transaction-level reference model
module tb_data_sram_axi_bridge;
`ifdef BRIDGE_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  logic        clk, reset, req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;
  logic [3:0]  arid, awid, arcache, awcache;
  logic [31:0] araddr, awaddr, axi_rdata, axi_wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arlock, awlock, arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  axi_wstrb;

  data_sram_axi_bridge #(.ID(4'd1)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .axi_rdata(axi_rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_cmp = 0, n_bad = 0;
  int n_dok = 0, n_arv = 0, n_awv = 0, n_wv = 0, n_both = 0;
  int cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  logic [31:0] cfg_rdata = 0;
  logic [1:0]  cfg_rresp = 0, cfg_bresp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // AXI slave stub: each ready/valid rises after the configured number of waiting cycles
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    axi_rdata = 0; rresp = 0; bresp = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      end else begin
        arready = arvalid && ar_c >= cfg_ar; ar_c = arvalid ? ar_c + 1 : 0;
        rvalid  = rready && r_c >= cfg_r;    r_c  = rready ? r_c + 1 : 0;
        awready = awvalid && aw_c >= cfg_aw; aw_c = awvalid ? aw_c + 1 : 0;
        wready  = wvalid && w_c >= cfg_w;    w_c  = wvalid ? w_c + 1 : 0;
        bvalid  = bready && b_c >= cfg_b;    b_c  = bready ? b_c + 1 : 0;
        axi_rdata = cfg_rdata; rresp = cfg_rresp; bresp = cfg_bresp;
      end
    end
  end

  // reference model: one outstanding transaction, tracked as a set of channel-completion flags
  initial begin
    logic out_m, rd_m, ar_m, r_m, aw_m, w_m, exp_dok, dok_rd, nd;
    logic [31:0] a_addr, a_wdata, rdata_m;
    logic [1:0] a_size;
    logic [3:0] a_wstrb;
    logic err_m;
    out_m = 0; rd_m = 0; ar_m = 0; r_m = 0; aw_m = 0; w_m = 0; exp_dok = 0; dok_rd = 0;
    a_addr = 0; a_wdata = 0; rdata_m = 0; a_size = 0; a_wstrb = 0; err_m = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        out_m = 0; exp_dok = 0; rdata_m = 0; err_m = 0;
      end
      n_dok += int'(data_ok); n_arv += int'(arvalid); n_awv += int'(awvalid); n_wv += int'(wvalid);
      n_both += int'(addr_ok && data_ok);
      chk("addr_ok", addr_ok, req & ~out_m);
      chk("data_ok", data_ok, exp_dok);
      if (exp_dok && dok_rd) chk("rdata", rdata, rdata_m);
      chk("arvalid", arvalid, out_m & rd_m & ~ar_m);
      chk("rready", rready, out_m & rd_m & ar_m);
      chk("awvalid", awvalid, out_m & ~rd_m & ~aw_m);
      chk("wvalid", wvalid, out_m & ~rd_m & ~w_m);
      chk("bready", bready, out_m & ~rd_m & aw_m & w_m);
      chk("err", err, err_m);
      if (arvalid) begin
        chk("araddr", araddr, a_addr);
        chk("arsize", arsize, {1'b0, a_size});
      end
      if (awvalid) begin
        chk("awaddr", awaddr, a_addr);
        chk("awsize", awsize, {1'b0, a_size});
      end
      if (wvalid) begin
        chk("wdata", axi_wdata, a_wdata);
        chk("wstrb", axi_wstrb, a_wstrb);
      end
      nd = 0;
      if (!reset) begin
        if (out_m && rd_m) begin
          if (!ar_m) ar_m = arready;
          else if (rvalid) begin
            rdata_m = axi_rdata; nd = 1; out_m = 0;
            err_m = err_m | (ERR_EN & (rresp != 0));
          end
        end else if (out_m) begin
          if (!aw_m || !w_m) begin
            aw_m = aw_m | awready;
            w_m = w_m | wready;
          end else if (bvalid) begin
            nd = 1; out_m = 0;
            err_m = err_m | (ERR_EN & (bresp != 0));
          end
        end else if (req) begin
          a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
          a_size = (size == 2'b11) ? 2'b10 : size;
          rd_m = ~wr; ar_m = 0; r_m = 0; aw_m = 0; w_m = 0; out_m = 1;
        end
      end
      dok_rd = rd_m;
      exp_dok = nd;
    end
  end

  task automatic issue(input logic w, input logic [1:0] s, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = 0;
    req = 1; wr = w; size = s; wstrb = st; addr = a; wdata = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = addr_ok;
    end
    chk("accept", {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
    req = 0;
  endtask

  task automatic wait_dok(input int target);
    for (int i = 0; i < 100 && n_dok < target; i++) @(negedge clk);
    chk("dok_wait", {31'b0, n_dok >= target}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, aw0, w0, b0;
    reset = 1; req = 0; wr = 0; size = 0; wstrb = 0; addr = 0; wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_data_ok", {31'b0, data_ok}, 32'h0);
    chk("rst_arvalid", {31'b0, arvalid}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("tie_arlen", {24'b0, arlen}, 32'h0);
    chk("tie_awburst", {30'b0, awburst}, 32'h1);
    chk("tie_arid", {28'b0, arid}, 32'h1);
    chk("tie_wlast", {31'b0, wlast}, 32'h1);
    @(posedge clk); #2; reset = 0;
    @(posedge clk); #1;

    // single read, zero-wait address, data one cycle after rready
    cfg_ar = 0; cfg_r = 1; cfg_rdata = 32'hdeadbeef;
    d0 = n_dok; a0 = n_arv;
    issue(0, 2'd2, 4'h0, 32'h1c000100, 32'h0);
    wait_dok(d0 + 1);
    repeat (2) @(negedge clk);
    chk("rd_arv_cycles", n_arv - a0, 1);
    chk("rd_dok_count", n_dok - d0, 1);
    chk("rd_rdata", rdata, 32'hdeadbeef);

    // write with W accepted first and AW three cycles in
    @(posedge clk); #1;
    cfg_aw = 2; cfg_w = 0; cfg_b = 0; cfg_bresp = 0;
    d0 = n_dok; aw0 = n_awv; w0 = n_wv;
    issue(1, 2'd2, 4'b0011, 32'h00000040, 32'h12345678);
    wait_dok(d0 + 1);
    repeat (2) @(negedge clk);
    chk("wr_wv_cycles", n_wv - w0, 1);
    chk("wr_awv_cycles", n_awv - aw0, 3);
    chk("wr_dok_count", n_dok - d0, 1);

    // back-to-back read then write with req held
    @(posedge clk); #1;
    cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 0; cfg_rdata = 32'hcafef00d;
    d0 = n_dok; b0 = n_both;
    issue(0, 2'd1, 4'h0, 32'h00000080, 32'h0);
    issue(1, 2'd0, 4'b0100, 32'h00000086, 32'h00a50000);
    wait_dok(d0 + 2);
    repeat (2) @(negedge clk);
    chk("b2b_dok_count", n_dok - d0, 2);
    chk("b2b_overlap", n_both - b0, 1);
    chk("b2b_rdata", rdata, 32'hcafef00d);

    // address stall of five cycles, size 3 clamps to word, second read queued behind it
    @(posedge clk); #1;
    cfg_ar = 5; cfg_rdata = 32'h5a5a0001;
    d0 = n_dok; a0 = n_arv;
    issue(0, 2'd3, 4'h0, 32'h00000100, 32'h0);
    issue(0, 2'd0, 4'h0, 32'h00000107, 32'h0);
    wait_dok(d0 + 2);
    repeat (2) @(negedge clk);
    chk("stall_arv_cycles", n_arv - a0, 12);
    chk("stall_dok_count", n_dok - d0, 2);

    // reset while waiting for read data abandons the transaction
    @(posedge clk); #1;
    cfg_ar = 0; cfg_r = 3;
    issue(0, 2'd2, 4'h0, 32'h00000200, 32'h0);
    @(posedge clk); #2;
    chk("pre_rst_rready", {31'b0, rready}, 32'h1);
    reset = 1;
    #1;
    chk("rst_now_rready", {31'b0, rready}, 32'h0);
    chk("rst_now_arvalid", {31'b0, arvalid}, 32'h0);
    chk("rst_now_data_ok", {31'b0, data_ok}, 32'h0);
    d0 = n_dok;
    repeat (2) @(posedge clk);
    #2; reset = 0;
    repeat (6) @(negedge clk);
    chk("rst_no_dok", n_dok - d0, 0);
    @(posedge clk); #1;
    cfg_r = 0; cfg_rdata = 32'h0badf00d;
    issue(0, 2'd2, 4'h0, 32'h00000204, 32'h0);
    wait_dok(d0 + 1);
    repeat (2) @(negedge clk);
    chk("post_rst_rdata", rdata, 32'h0badf00d);

    // error response on a write, then an OKAY read; err sticks only when enabled
    @(posedge clk); #1;
    cfg_bresp = 2'b10; cfg_rresp = 0;
    d0 = n_dok;
    issue(1, 2'd2, 4'h0, 32'h00000300, 32'h11112222);
    wait_dok(d0 + 1);
    cfg_bresp = 0;
    issue(0, 2'd2, 4'h0, 32'h00000304, 32'h0);
    wait_dok(d0 + 2);
    repeat (2) @(negedge clk);
    chk("err_sticky", {31'b0, err}, {31'b0, ERR_EN});
    @(posedge clk); #2; reset = 1;
    @(posedge clk); #2; reset = 0;
    @(negedge clk);
    chk("err_cleared", {31'b0, err}, 32'h0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's data-memory port.
- Accepts one request at a time on an SRAM-like req/addr_ok/data_ok handshake.
- Issues exactly one single-beat AXI read or write per request. Returns read data or write completion.
- Top level ties the remaining AXI fields: len=0, burst=INCR, lock/cache/prot=0, wlast=1, id=ID.

Parameters:
- ID, 4'd1, constant AXI transaction id. Echoed only at top level; never checked on return.

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
req  in  1  CPU request valid
wr  in  1  1=write, 0=read
size  in  2  0=byte, 1=half, 2=word
wstrb  in  4  write byte enables
addr  in  32  byte address
wdata  in  32  write data
addr_ok  out  1  request accepted this cycle
data_ok  out  1  one-cycle completion pulse
rdata  out  32  read result, valid while data_ok=1
err  out  1  sticky response-error flag (see Optional Feature)
araddr  out  32  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AXI read-address valid
arready  in  1  AXI read-address ready
axi_rdata  in  32  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI read-data valid
rready  out  1  AXI read-data ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI write-address valid
awready  in  1  AXI write-address ready
axi_wdata  out  32  AXI write data
axi_wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write-data valid
wready  in  1  AXI write-data ready
bresp  in  2  AXI write response
bvalid  in  1  AXI write-response valid
bready  out  1  AXI write-response ready

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Reset (async): state=IDLE; arvalid, awvalid, wvalid, rready, bready, data_ok, err = 0; rdata=0; latched request fields = 0.
- Reset mid-transaction: the transaction is abandoned and no data_ok is produced.
- addr_ok = req & (state==IDLE), combinational.
- On req&addr_ok: latch wr, size, wstrb, addr, wdata; go to RD_ADDR (wr=0) or WR_REQ (wr=1).
- size 2'b11 is treated as 2'b10.
- arsize/awsize = {1'b0, size}.
- RD_ADDR: arvalid=1; araddr and arsize held stable until arready. On arvalid&arready go to RD_DATA and drop arvalid.
- RD_DATA: rready=1. On rvalid, register axi_rdata into rdata, pulse data_ok on the next cycle, return to IDLE.
- WR_REQ: awvalid and wvalid both assert on entry. Each deasserts independently on its own ready; per-channel done flags permit either order or the same cycle. When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, pulse data_ok on the next cycle, return to IDLE.
- data_ok is registered and high for exactly 1 cycle per request. rdata holds its value until the next read completes; on writes it is don't-care.
- addr_ok may be high in the same cycle data_ok is high (back-to-back requests). Never more than one request outstanding.
- Minimum latency with zero-wait slave:
  - read: accept at cycle 0, arvalid cycle 1, rready cycle 2, data_ok cycle 3.
  - write: accept at cycle 0, aw/w cycle 1, bready cycle 2, data_ok cycle 3.
- A write with wstrb=0 is still issued on the bus.
- Valid signals never drop before their ready; payloads are stable while valid is high.

Optional Feature:
- Macro BRIDGE_RESP_ERR_EN.
- Defined: err is set when rresp!=0 at the rvalid&rready handshake or bresp!=0 at the bvalid&bready handshake. It stays set until reset. Completion behaviour is unchanged.
- Undefined: err is tied to 0 and no error-capture logic is present.

Test Plan:
- Read 0x1c000100, size 2; arready=1 immediately; rvalid 2 cycles later with 0xdeadbeef -> arvalid high exactly 1 cycle; data_ok 1 cycle with rdata=0xdeadbeef.
- Write 0x00000040, wdata 0x12345678, wstrb 4'b0011; wready in cycle 1, awready in cycle 3 -> wvalid drops after cycle 1, awvalid after cycle 3; bready only after both; single data_ok after bvalid.
- Read then write back-to-back, req held high; second request offered in the data_ok cycle -> addr_ok high that cycle; second transaction starts the next cycle; exactly two data_ok pulses.
- arready held 0 for 5 cycles -> arvalid and araddr stable all 5 cycles; addr_ok=0 throughout; data_ok after the eventual R handshake.
- reset asserted while in RD_DATA -> arvalid, rready and data_ok go 0 immediately; no data_ok after deassert; next read completes normally.
- BRIDGE_RESP_ERR_EN defined, write with bresp=2'b10 -> err=1 from the cycle after the handshake and stays 1 through later OKAY transactions until reset. Undefined -> err stays 0.
